// File: rtl/stream_mux.sv
// Registered N:1 stream mux with fixed select or optional round-robin (STREAM_MUX_RR_EN).
// Latency: 1 cycle from input transfer to out_valid; single-entry output register.
// Backpressure: in_ready is granted only when the output register is empty or draining this cycle.
module stream_mux #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 8,
  localparam int SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  input  logic [NUM_CH-1:0]        in_valid,
  output logic [NUM_CH-1:0]        in_ready,
  input  logic                     sel_mode,
  input  logic [SEL_W-1:0]         sel,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [SEL_W-1:0]         out_ch
);

  logic [NUM_CH-1:0] grant;
  logic [SEL_W-1:0]  grant_ch;
  logic [DATA_W-1:0] sel_data;
  logic              load_en;
  logic              in_xfer;

`ifdef STREAM_MUX_RR_EN
  logic [SEL_W-1:0] rr_ptr;
  logic [SEL_W:0]   idx;

  // Scan downward so the channel closest to rr_ptr is the last (winning) assignment.
  always_comb begin
    grant    = '0;
    grant_ch = '0;
    idx      = '0;
    if (sel_mode) begin
      for (int k = NUM_CH - 1; k >= 0; k--) begin
        idx = {1'b0, rr_ptr} + (SEL_W+1)'(k);
        if (idx >= (SEL_W+1)'(NUM_CH)) idx = idx - (SEL_W+1)'(NUM_CH);
        if (in_valid[idx[SEL_W-1:0]]) begin
          grant                   = '0;
          grant[idx[SEL_W-1:0]]   = 1'b1;
          grant_ch                = idx[SEL_W-1:0];
        end
      end
    end else if ({1'b0, sel} < (SEL_W+1)'(NUM_CH)) begin
      grant[sel] = in_valid[sel];
      grant_ch   = sel;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (in_xfer && sel_mode) begin
      rr_ptr <= (grant_ch == SEL_W'(NUM_CH - 1)) ? '0 : grant_ch + 1'b1;
    end
  end
`else
  logic unused_sel_mode;
  assign unused_sel_mode = sel_mode;

  always_comb begin
    grant    = '0;
    grant_ch = '0;
    if ({1'b0, sel} < (SEL_W+1)'(NUM_CH)) begin
      grant[sel] = in_valid[sel];
      grant_ch   = sel;
    end
  end
`endif

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (grant[i]) sel_data = in_data[i*DATA_W +: DATA_W];
    end
  end

  assign load_en  = !out_valid || out_ready;
  // rst_n gates ready directly: out_valid is 0 in reset, so load_en alone would be 1.
  assign in_ready = grant & {NUM_CH{load_en & rst_n}};
  assign in_xfer  = |in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
    end else if (load_en) begin
      out_valid <= in_xfer;
      if (in_xfer) begin
        out_data <= sel_data;
        out_ch   <= grant_ch;
      end
    end
  end

endmodule

// File: tb/tb_stream_mux.sv
// Directed, table-driven bench for stream_mux; round-robin sequences run when STREAM_MUX_RR_EN is defined.
module tb_stream_mux;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] in_data = 32'h3CA52211;
  logic [3:0]  in_valid = '0;
  logic [3:0]  in_ready;
  logic        sel_mode = 1'b0;
  logic [1:0]  sel = '0;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [1:0]  out_ch;

  // Three-channel instance held at an out-of-range select.
  logic [23:0] in_data3 = 24'h332211;
  logic [2:0]  in_valid3 = 3'b111;
  logic [2:0]  in_ready3;
  logic [1:0]  sel3 = 2'd3;
  logic [7:0]  out_data3;
  logic        out_valid3;
  logic [1:0]  out_ch3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  stream_mux #(.NUM_CH(4), .DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .sel_mode(sel_mode), .sel(sel), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_ch(out_ch)
  );

  stream_mux #(.NUM_CH(3), .DATA_W(8)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data3), .in_valid(in_valid3), .in_ready(in_ready3),
    .sel_mode(1'b0), .sel(sel3), .out_data(out_data3), .out_valid(out_valid3),
    .out_ready(1'b1), .out_ch(out_ch3)
  );

  typedef struct {
    logic [1:0] sel;
    logic [3:0] vld;
    logic       ordy;
    logic [3:0] exp_rdy;
    logic       exp_ov;
    logic [7:0] exp_od;
    logic [1:0] exp_oc;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive at negedge, check in_ready combinationally, then check registered outputs after the edge.
  task automatic step(input string tag, input logic m, input logic [1:0] s, input logic [3:0] v,
                      input logic r, input logic [3:0] e_rdy, input logic e_ov,
                      input logic [7:0] e_od, input logic [1:0] e_oc);
    @(negedge clk);
    sel_mode  = m;
    sel       = s;
    in_valid  = v;
    out_ready = r;
    #1;
    chk({tag, " in_ready"}, 32'(in_ready), 32'(e_rdy));
    @(posedge clk);
    #1;
    chk({tag, " out_valid"}, 32'(out_valid), 32'(e_ov));
    chk({tag, " out_data"}, 32'(out_data), 32'(e_od));
    chk({tag, " out_ch"}, 32'(out_ch), 32'(e_oc));
  endtask

  initial begin
    //           sel   vld      ordy  rdy      ov    od      oc
    vecs[0] = '{2'd2, 4'b1111, 1'b1, 4'b0100, 1'b1, 8'hA5, 2'd2};
    vecs[1] = '{2'd0, 4'b0001, 1'b1, 4'b0001, 1'b1, 8'h11, 2'd0};
    vecs[2] = '{2'd1, 4'b0000, 1'b1, 4'b0000, 1'b0, 8'h11, 2'd0};
    vecs[3] = '{2'd3, 4'b1000, 1'b0, 4'b1000, 1'b1, 8'h3C, 2'd3};
    vecs[4] = '{2'd1, 4'b0010, 1'b0, 4'b0000, 1'b1, 8'h3C, 2'd3};
    vecs[5] = '{2'd1, 4'b0010, 1'b0, 4'b0000, 1'b1, 8'h3C, 2'd3};
    vecs[6] = '{2'd1, 4'b0010, 1'b0, 4'b0000, 1'b1, 8'h3C, 2'd3};
    vecs[7] = '{2'd1, 4'b0010, 1'b1, 4'b0010, 1'b1, 8'h22, 2'd1};
    vecs[8] = '{2'd2, 4'b0100, 1'b1, 4'b0100, 1'b1, 8'hA5, 2'd2};
    vecs[9] = '{2'd0, 4'b1110, 1'b1, 4'b0000, 1'b0, 8'hA5, 2'd2};

    // Reset state, with valid inputs present to show ready stays low.
    in_valid = 4'b1111;
    sel      = 2'd2;
    repeat (2) @(posedge clk);
    #1;
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset out_data", 32'(out_data), 32'd0);
    chk("reset out_ch", 32'(out_ch), 32'd0);
    chk("reset in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      step($sformatf("vec%0d", i), 1'b0, vecs[i].sel, vecs[i].vld, vecs[i].ordy,
           vecs[i].exp_rdy, vecs[i].exp_ov, vecs[i].exp_od, vecs[i].exp_oc);
    end

    // Out-of-range select on the three-channel instance never grants.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("ch3 in_ready", 32'(in_ready3), 32'd0);
      chk("ch3 out_valid", 32'(out_valid3), 32'd0);
    end

    // Load a word, stall it, then assert reset between edges.
    step("preload", 1'b0, 2'd3, 4'b1000, 1'b0, 4'b1000, 1'b1, 8'h3C, 2'd3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst out_valid", 32'(out_valid), 32'd0);
    chk("midrst out_data", 32'(out_data), 32'd0);
    chk("midrst out_ch", 32'(out_ch), 32'd0);
    chk("midrst in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    step("rr0", 1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 8'h11, 2'd0);
`ifdef STREAM_MUX_RR_EN
    step("rr1", 1'b1, 2'd0, 4'b1111, 1'b1, 4'b0010, 1'b1, 8'h22, 2'd1);
    step("rr2", 1'b1, 2'd0, 4'b1111, 1'b1, 4'b0100, 1'b1, 8'hA5, 2'd2);
    step("rr3", 1'b1, 2'd0, 4'b1111, 1'b1, 4'b1000, 1'b1, 8'h3C, 2'd3);
    step("rr4", 1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 8'h11, 2'd0);
    step("rr5", 1'b1, 2'd0, 4'b1111, 1'b1, 4'b0010, 1'b1, 8'h22, 2'd1);
    step("rr6", 1'b1, 2'd0, 4'b1111, 1'b1, 4'b0100, 1'b1, 8'hA5, 2'd2);
    step("rrwrap1", 1'b1, 2'd0, 4'b0010, 1'b1, 4'b0010, 1'b1, 8'h22, 2'd1);
    step("rrwrap2", 1'b1, 2'd0, 4'b1001, 1'b1, 4'b1000, 1'b1, 8'h3C, 2'd3);
    step("fixed_in_rr", 1'b0, 2'd2, 4'b0100, 1'b1, 4'b0100, 1'b1, 8'hA5, 2'd2);
    step("rr_after_fix", 1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 8'h11, 2'd0);
`else
    step("mode_ign1", 1'b1, 2'd3, 4'b1111, 1'b1, 4'b1000, 1'b1, 8'h3C, 2'd3);
    step("mode_ign2", 1'b1, 2'd1, 4'b0001, 1'b1, 4'b0000, 1'b0, 8'h3C, 2'd3);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/stream_mux.md
STREAM_MUX -- requirements
Module: stream_mux

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of input channels (legal 2..16).
REQ-002 SHALL have parameter DATA_W, default 8, data bits per channel (legal 1..64).
REQ-003 SHALL derive local SEL_W = clog2(NUM_CH).
REQ-004 SHALL use one clock, rising edge, with asynchronous active-low reset:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
REQ-005 SHALL have data and select ports:
- in_data  input  NUM_CH*DATA_W  channel i occupies bits [i*DATA_W +: DATA_W]
- in_valid  input  NUM_CH  per-channel valid
- in_ready  output  NUM_CH  per-channel ready
- sel_mode  input  1  0 = fixed select, 1 = round-robin
- sel  input  SEL_W  channel index, used when sel_mode=0
REQ-006 SHALL have output ports:
- out_data  output  DATA_W  registered selected data
- out_valid  output  1  registered output valid
- out_ready  input  1  downstream ready
- out_ch  output  SEL_W  index of the channel that supplied out_data

Function
REQ-007 SHALL hold a single-entry output register; load_en = !out_valid | out_ready.
REQ-008 SHALL transfer on an input when in_valid[i] & in_ready[i]; on an output when out_valid & out_ready.
REQ-009 SHALL assert at most one in_ready bit per cycle: in_ready[i] = load_en & grant[i].
REQ-010 SHALL form grant combinationally from in_valid, sel_mode, sel and the RR pointer; no input-side buffering.
REQ-011 Fixed mode SHALL set grant[sel]=in_valid[sel], with all other grants 0.
REQ-012 Fixed mode with sel >= NUM_CH SHALL grant nothing: all in_ready=0 and no load.
REQ-013 RR mode SHALL grant the first channel with in_valid=1, searching upward from rr_ptr and wrapping NUM_CH-1 -> 0.
REQ-014 After each RR input transfer on channel g, rr_ptr SHALL become (g+1) mod NUM_CH; otherwise rr_ptr SHALL hold.
REQ-015 Fixed-mode transfers SHALL NOT change rr_ptr.
REQ-016 On an input transfer, out_data, out_ch and out_valid=1 SHALL update at the next rising edge (latency 1 cycle).
REQ-017 With load_en=1 and no input transfer, out_valid SHALL go 0 at the next edge; out_data and out_ch SHALL hold.
REQ-018 While out_valid=1 and out_ready=0, out_data, out_ch and out_valid SHALL hold stable and all in_ready SHALL be 0.
REQ-019 A simultaneous output transfer and input transfer in one cycle SHALL sustain full throughput (one word per cycle).
REQ-020 A change of sel_mode or sel SHALL take effect in the same cycle's grant and SHALL NOT affect a word already in the output register.
REQ-021 in_ready MAY depend on in_valid; in_valid SHALL NOT be required to depend on in_ready, so no combinational loop forms.
REQ-022 The block SHALL never drop or duplicate a word; each input transfer yields exactly one output transfer, in order.

Reset
REQ-023 While rst_n=0, asynchronously: out_valid=0, out_data=0, out_ch=0, rr_ptr=0.
REQ-024 While rst_n=0, in_ready SHALL be all 0.
REQ-025 Reset asserted mid-transfer SHALL discard the held word without an output transfer.
REQ-026 The first grant after reset release SHALL be evaluated at the first rising edge with rst_n=1.

Configuration
REQ-027 Macro STREAM_MUX_RR_EN SHALL compile round-robin mode in.
REQ-028 With STREAM_MUX_RR_EN defined, behaviour SHALL follow REQ-013..REQ-015 when sel_mode=1.
REQ-029 Without STREAM_MUX_RR_EN, sel_mode SHALL be ignored (always fixed mode), rr_ptr SHALL not exist, and all other behaviour SHALL be identical.

Verification
REQ-030 Fixed mode, NUM_CH=4, DATA_W=8, sel=2, in_valid=4'b1111, in_data ch2=0xA5, out_ready=1 -> next cycle out_valid=1, out_data=0xA5, out_ch=2; in_ready=4'b0100.
REQ-031 Backpressure: out_ready=0 for 3 cycles with out_valid=1 holding 0x3C -> out_data stays 0x3C and in_ready=0 throughout; out_ready=1 -> transfer, next word loads the same cycle.
REQ-032 RR mode, all four valid continuously, out_ready=1 -> out_ch sequence 0,1,2,3,0,1 with one word per cycle.
REQ-033 RR wrap: rr_ptr=3, in_valid=4'b0010 -> ch1 granted, rr_ptr becomes 2; then in_valid=4'b1001 -> ch3 granted.
REQ-034 Fixed mode, sel=3, NUM_CH=3 -> in_ready=0, out_valid stays 0 for all cycles.
REQ-035 Assert rst_n=0 mid-cycle with out_valid=1 -> out_valid, out_data and out_ch go 0 immediately without waiting for clk; after release with in_valid[0]=1 in RR mode -> first out_ch=0.
